// File: rtl/wb_imem_loader.sv
// Wishbone classic responder that holds the core in reset and streams IMEM bytes in and out.
// Optional macro WB_LOADER_IRQ_EN drives irq_o from the sticky error flag.
module wb_imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IMEM_AW   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [7:0]         imem_wdata_o,
    input  logic [7:0]         imem_rdata_i,
    output logic               cpu_rst_n_o,
    output logic               irq_o
);

    typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

    state_t        state, next_state;
    logic          hold, err;
    logic [15:0]   count;
    logic [3:0]    pend;
    logic [31:0]   wr_data;
    logic [2:0]    rd_cnt;
    logic [23:0]   rd_buf;

    logic          req, imem_hit, ctrl_hit, status_hit;
    logic [31:0]   reg_rdata;
    logic [1:0]    req_lane, pend_lane;
    logic [IMEM_AW-3:0] req_word;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        low_lane = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) low_lane = 2'(i);
    endfunction

    assign req        = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign imem_hit   = (wbs_adr_i[11:10] == 2'b01) && ((wbs_adr_i[9:0] >> IMEM_AW) == 10'd0);
    assign ctrl_hit   = (wbs_adr_i[11:2] == 10'd0);
    assign status_hit = (wbs_adr_i[11:2] == 10'd1);
    assign req_word   = wbs_adr_i[IMEM_AW-1:2];
    assign req_lane   = low_lane(wbs_sel_i);
    assign pend_lane  = low_lane(pend);

    // Byte writes are gated by cyc so an aborted cycle stops mid-burst.
    assign imem_we_o   = (state == WR) && wbs_cyc_i;
    assign cpu_rst_n_o = ~hold;

`ifdef WB_LOADER_IRQ_EN
    assign irq_o = err;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        reg_rdata = 32'h0;
        if (ctrl_hit)        reg_rdata = {31'h0, hold};
        else if (status_hit) reg_rdata = {15'h0, err, count};
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (req) begin
                if (imem_hit && hold && wbs_we_i && (wbs_sel_i != 4'h0)) next_state = WR;
                else if (imem_hit && hold && !wbs_we_i)                  next_state = RD;
                else                                                     next_state = ACK;
            end
            WR:   if (!wbs_cyc_i)         next_state = IDLE;
                  else if (pend == 4'h0)  next_state = ACK;
            RD:   if (!wbs_cyc_i)         next_state = IDLE;
                  else if (rd_cnt == 3'd4) next_state = ACK;
            ACK:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else             state <= next_state;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= 32'h0;
            imem_addr_o  <= '0;
            imem_wdata_o <= 8'h0;
            hold         <= 1'b1;
            err          <= 1'b0;
            count        <= 16'h0;
            pend         <= 4'h0;
            wr_data      <= 32'h0;
            rd_cnt       <= 3'd0;
            rd_buf       <= 24'h0;
        end else begin
            wbs_ack_o <= (next_state == ACK);
            wbs_dat_o <= 32'h0;

            if (imem_we_o && (count != 16'hFFFF))
                count <= count + 16'd1;

            unique case (state)
                IDLE: if (req) begin
                    if (!imem_hit) begin
                        if (!wbs_we_i)
                            wbs_dat_o <= reg_rdata;
                        else if (ctrl_hit && wbs_sel_i[0]) begin
                            hold <= wbs_dat_i[0];
                            if (wbs_dat_i[2]) begin
                                count <= 16'h0;
                                err   <= 1'b0;
                            end
                        end
                    end else if (wbs_we_i) begin
                        if (!hold)
                            err <= 1'b1;
                        else if (wbs_sel_i != 4'h0) begin
                            wr_data      <= wbs_dat_i;
                            imem_addr_o  <= {req_word, req_lane};
                            imem_wdata_o <= wbs_dat_i[8*req_lane +: 8];
                            pend         <= wbs_sel_i & ~(4'b0001 << req_lane);
                        end
                    end else if (hold) begin
                        imem_addr_o <= {req_word, 2'b00};
                        rd_cnt      <= 3'd0;
                    end
                end
                WR: if (imem_we_o && (pend != 4'h0)) begin
                    imem_addr_o  <= {imem_addr_o[IMEM_AW-1:2], pend_lane};
                    imem_wdata_o <= wr_data[8*pend_lane +: 8];
                    pend         <= pend & ~(4'b0001 << pend_lane);
                end
                RD: if (wbs_cyc_i) begin
                    // Read data trails the address by one cycle, so capture lags the address walk.
                    if (rd_cnt < 3'd3) imem_addr_o <= imem_addr_o + 1'b1;
                    case (rd_cnt)
                        3'd1: rd_buf[7:0]   <= imem_rdata_i;
                        3'd2: rd_buf[15:8]  <= imem_rdata_i;
                        3'd3: rd_buf[23:16] <= imem_rdata_i;
                        3'd4: wbs_dat_o     <= {imem_rdata_i, rd_buf};
                        default: ;
                    endcase
                    rd_cnt <= rd_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
